// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NZCV bit positions, condition encodings, status type.
package cpu_pkg;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef logic [3:0] status_t;

endpackage

// File: rtl/status_flag_unit_pend_counter.sv
// Up/down saturating counter with synchronous clear.
//  clk, rst : clock, async active-high reset
//  clr      : synchronous clear, overrides inc/dec
//  inc, dec : count up / down; both together hold
//  cnt      : current count
module pend_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Saturate at both ends so an illegal sequence cannot wrap the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/status_flag_unit.sv
// Architectural NZCV register, in-flight flag-writer tracking and ID flag hazard.
//  clk, rst           : clock, async active-high reset
//  exe_valid/s_en     : EXE live instruction / writes flags
//  exe_flags          : ALU flags {N,Z,C,V} from EXE
//  id_valid/cond/s_en : ID live instruction / condition field / writes flags
//  freeze             : external ID stall
//  flush              : branch taken, kills ID and in-flight writers
//  status_r           : architectural status register
//  status_fwd         : flags for the ID condition check (combinational)
//  flag_hazard        : ID must stall this cycle (combinational)
//  pend_cnt           : number of flag writers between ID issue and EXE commit
module status_flag_unit
    import cpu_pkg::*;
#(
    parameter int unsigned FLAG_W = 4,
    parameter int unsigned PEND_W = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic              exe_s_en,
    input  logic [FLAG_W-1:0] exe_flags,
    input  logic              id_valid,
    input  logic [3:0]        id_cond,
    input  logic              id_s_en,
    input  logic              freeze,
    input  logic              flush,
    output logic [FLAG_W-1:0] status_r,
    output logic [FLAG_W-1:0] status_fwd,
    output logic              flag_hazard,
    output logic [PEND_W-1:0] pend_cnt
);

    localparam logic [PEND_W-1:0] MAX_PEND = '1;

    logic commit;
    logic cond_use;
    logic bypass_ok;
    logic issue;

    // Hazard and forward decisions.
    always_comb begin
        commit      = exe_valid && exe_s_en;
        cond_use    = id_valid && (id_cond != COND_AL);
        // Only the last outstanding writer may be forwarded; older ones would be stale.
        bypass_ok   = BYPASS && commit && (pend_cnt == PEND_W'(1));
        flag_hazard = (cond_use && (pend_cnt != '0) && !bypass_ok)
                    || (id_valid && id_s_en && (pend_cnt == MAX_PEND) && !commit);
        status_fwd  = bypass_ok ? exe_flags : status_r;
        issue       = id_valid && id_s_en && !freeze && !flag_hazard && !flush;
    end

    // Commit ignores flush: the flushing branch itself is the committing instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r <= '0;
        end else if (commit) begin
            status_r <= exe_flags;
        end
    end

    pend_counter #(
        .W (PEND_W)
    ) u_pend_counter (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (issue),
        .dec (commit),
        .cnt (pend_cnt)
    );

    a_no_commit_underflow: assert property (
        @(posedge clk) disable iff (rst)
        !(commit && !issue && !flush && (pend_cnt == '0))
    );

endmodule

// File: tb/tb_status_flag_unit.sv
module tb_status_flag_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       exe_valid, exe_s_en, id_valid, id_s_en, freeze, flush;
    logic [3:0] exe_flags, id_cond;

    logic [3:0] a_status_r, a_status_fwd, b_status_r, b_status_fwd;
    logic       a_hazard, b_hazard;
    logic [1:0] a_pend, b_pend;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    status_flag_unit #(.FLAG_W(4), .PEND_W(2), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s_en(exe_s_en),
        .exe_flags(exe_flags), .id_valid(id_valid), .id_cond(id_cond),
        .id_s_en(id_s_en), .freeze(freeze), .flush(flush),
        .status_r(a_status_r), .status_fwd(a_status_fwd),
        .flag_hazard(a_hazard), .pend_cnt(a_pend)
    );

    status_flag_unit #(.FLAG_W(4), .PEND_W(2), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_s_en(exe_s_en),
        .exe_flags(exe_flags), .id_valid(id_valid), .id_cond(id_cond),
        .id_s_en(id_s_en), .freeze(freeze), .flush(flush),
        .status_r(b_status_r), .status_fwd(b_status_fwd),
        .flag_hazard(b_hazard), .pend_cnt(b_pend)
    );

    function automatic void push(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        q.push_back(e);
    endfunction

    task automatic check(input logic [7:0] obs);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h expected none", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive(input logic ev, input logic es, input logic [3:0] ef,
                         input logic iv, input logic [3:0] ic, input logic is,
                         input logic fz, input logic fl);
        exe_valid = ev; exe_s_en = es; exe_flags = ef;
        id_valid  = iv; id_cond  = ic; id_s_en  = is;
        freeze    = fz; flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #12;
        push("reset_status_r", 8'h0);
        push("reset_pend", 8'h0);
        push("reset_hazard", 8'h0);
        check(8'(a_status_r));
        check(8'(a_pend));
        check(8'(a_hazard));
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Test 1: build pend=2, status=1010, then reset between edges.
        drive(1'b1, 1'b1, 4'b1010, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        idle();
        push("t1_pend_before", 8'd2);
        push("t1_status_before", 8'b1010);
        check(8'(a_pend));
        check(8'(a_status_r));
        #2 rst = 1'b1;
        #1;
        push("t1_pend_async", 8'd0);
        push("t1_status_async", 8'd0);
        push("t1_fwd_async", 8'd0);
        check(8'(a_pend));
        check(8'(a_status_r));
        check(8'(a_status_fwd));
        #1 rst = 1'b0;
        tick();
        push("t1_pend_hold", 8'd0);
        push("t1_status_hold", 8'd0);
        check(8'(a_pend));
        check(8'(a_status_r));

        // Test 2: ADDS then EQ without commit stalls.
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        push("t2_pend", 8'd1);
        push("t2_hazard_a", 8'd1);
        push("t2_hazard_b", 8'd1);
        check(8'(a_pend));
        check(8'(a_hazard));
        check(8'(b_hazard));
        tick();

        // Test 3/4: EXE commits 0100 in the EQ cycle.
        drive(1'b1, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        push("t3_hazard_byp", 8'd0);
        push("t3_fwd_byp", 8'b0100);
        push("t4_hazard_nobyp", 8'd1);
        push("t4_fwd_nobyp", 8'b0000);
        check(8'(a_hazard));
        check(8'(a_status_fwd));
        check(8'(b_hazard));
        check(8'(b_status_fwd));
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        push("t4_status_nobyp", 8'b0100);
        push("t4_hazard_after", 8'd0);
        push("t4_pend_after", 8'd0);
        push("t4_fwd_after", 8'b0100);
        check(8'(b_status_r));
        check(8'(b_hazard));
        check(8'(b_pend));
        check(8'(b_status_fwd));
        tick();

        // Test 5: fill to MAX_PEND, then another S instruction.
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        #1;
        push("t5_pend_full", 8'd3);
        push("t5_hazard_full", 8'd1);
        check(8'(a_pend));
        check(8'(a_hazard));
        tick();
        push("t5_pend_held", 8'd3);
        check(8'(a_pend));
        drive(1'b1, 1'b1, 4'b0011, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0);
        #1;
        push("t5_hazard_commit", 8'd0);
        check(8'(a_hazard));
        tick();
        push("t5_pend_swap", 8'd3);
        push("t5_status_swap", 8'b0011);
        check(8'(a_pend));
        check(8'(a_status_r));
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
        #1;
        push("t6_al_no_stall", 8'd0);
        check(8'(a_hazard));
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        #1;
        push("t6_eq_stall_full", 8'd1);
        check(8'(a_hazard));

        // Test 6: drain to 2, then flush together with commit of 0001.
        drive(1'b1, 1'b1, 4'b1000, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
        tick();
        push("t6_pend_two", 8'd2);
        check(8'(a_pend));
        drive(1'b1, 1'b1, 4'b0001, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b1);
        tick();
        push("t6_pend_flush", 8'd0);
        push("t6_status_flush", 8'b0001);
        push("t6_pend_flush_nb", 8'd0);
        check(8'(a_pend));
        check(8'(a_status_r));
        check(8'(b_pend));

        // Freeze blocks issue but commits still drain the count.
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b0);
        tick();
        push("frz_pend_hold", 8'd1);
        check(8'(a_pend));
        drive(1'b1, 1'b1, 4'b1001, 1'b1, 4'b1110, 1'b1, 1'b1, 1'b0);
        tick();
        push("frz_pend_drain", 8'd0);
        push("frz_status", 8'b1001);
        check(8'(a_pend));
        check(8'(a_status_r));
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
